dmem_sized: RTL

- Parametrised data memory for the single-cycle RISC-V core; successor to the fixed 256-word word-only data memory.
- Adds RV32I sub-word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) selected by funct3, with byte lanes and sign/zero extension.
- Flags misaligned, out-of-range and illegal-size accesses.
- After reset, a clear sequencer zeroes the array one word per cycle and raises busy, so the array needs no single-cycle reset of every word.

---
 rtl/dmem_sized.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_sized.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_sized
//  Purpose  : Parametrised word-organised data memory for the single-cycle
//             RISC-V core. Supports RV32I LB/LH/LW/LBU/LHU and SB/SH/SW
//             selected by funct3. Byte lanes are individually writable. Loads
//             are sign- or zero-extended. Misaligned, out-of-range and
//             illegal-size accesses are flagged and suppressed. After reset a
//             clear sequencer zeroes one word per cycle while busy is high.
//  Ports    : clk        system clock, rising edge
//             rst        synchronous active-high reset
//             MemRead    load request
//             MemWrite   store request
//             funct3     000 B, 001 H, 010 W, 100 BU, 101 HU
//             addr       byte address
//             WriteData  store data (low byte/half for SB/SH)
//             ReadData   extended load data (combinational)
//             busy       high while the clear sequence runs (registered)
//             fault      requested access suppressed (combinational)
//             rd_cnt     accepted-load counter   (DMEM_SIZED_CNT_EN only)
//             wr_cnt     accepted-store counter  (DMEM_SIZED_CNT_EN only)
//  Options  : define DMEM_SIZED_CNT_EN to add saturating access counters.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_sized #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        busy,
    output logic        fault
`ifdef DMEM_SIZED_CNT_EN
    ,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
`endif
);

    localparam logic [AW-1:0] c_LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [AW-1:0]   r_clrIdx;
    logic [AW-1:0]   w_nextClrIdx;

    logic [31:0]     r_mem [DEPTH];

    logic [AW-1:0]   w_idx;
    logic [1:0]      w_off;
    logic            w_req;
    logic            w_illegal;
    logic            w_misaligned;
    logic            w_oor;
    logic            w_rdOk;
    logic            w_wrOk;
    logic            w_clrWe;
    logic [3:0]      w_laneWe;
    logic [31:0]     w_wrData;
    logic [31:0]     w_word;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;

    assign w_idx = addr[AW+1:2];
    assign w_off = addr[1:0];

    // ------------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_CLEAR;
            r_clrIdx <= '0;
        end else begin
            r_state  <= w_nextState;
            r_clrIdx <= w_nextClrIdx;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_nextClrIdx = r_clrIdx;
        if (r_state == S_CLEAR) begin
            w_nextClrIdx = r_clrIdx + AW'(1);
            if (r_clrIdx == c_LAST_IDX) begin
                w_nextState = S_IDLE;
            end
        end
    end

    assign busy    = (r_state == S_CLEAR);
    assign w_clrWe = busy & ~rst;

    // ------------------------------------------------------------------------
    // Access checking
    // ------------------------------------------------------------------------
    assign w_req = MemRead | MemWrite;

    // Unsigned sizes (1xx) have no store counterpart, so they are illegal
    // whenever a store is requested, even if a load is requested alongside.
    always_comb begin
        w_illegal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
            3'b100, 3'b101:         w_illegal = MemWrite;
            default:                w_illegal = 1'b1;
        endcase
    end

    assign w_misaligned = ((funct3[1:0] == 2'b01) & w_off[0])
                        | ((funct3[1:0] == 2'b10) & (w_off != 2'b00));

    // Shift rather than slice so the check stays valid for any legal DEPTH.
    assign w_oor = ((addr >> (AW + 2)) != 32'd0);

    assign fault  = w_req & ~busy & (w_illegal | w_misaligned | w_oor);
    assign w_rdOk = MemRead  & ~busy & ~fault;
    assign w_wrOk = MemWrite & ~busy & ~fault & ~rst;

    // ------------------------------------------------------------------------
    // Store lanes: data is replicated across lanes so each enabled lane just
    // takes its own byte position.
    // ------------------------------------------------------------------------
    always_comb begin
        w_laneWe = 4'b0000;
        w_wrData = WriteData;
        case (funct3[1:0])
            2'b00: begin
                w_laneWe = 4'b0001 << w_off;
                w_wrData = {4{WriteData[7:0]}};
            end
            2'b01: begin
                w_laneWe = w_off[1] ? 4'b1100 : 4'b0011;
                w_wrData = {2{WriteData[15:0]}};
            end
            default: begin
                w_laneWe = 4'b1111;
                w_wrData = WriteData;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_clrWe) begin
            r_mem[r_clrIdx] <= 32'd0;
        end else if (w_wrOk) begin
            for (int i = 0; i < 4; i++) begin
                if (w_laneWe[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wrData[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Load path (shows pre-write contents on a same-cycle read/write)
    // ------------------------------------------------------------------------
    assign w_word = r_mem[w_idx];

    always_comb begin
        case (w_off)
            2'b00:   w_byte = w_word[7:0];
            2'b01:   w_byte = w_word[15:8];
            2'b10:   w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        ReadData = 32'd0;
        if (w_rdOk) begin
            case (funct3)
                3'b000:  ReadData = {{24{w_byte[7]}}, w_byte};
                3'b001:  ReadData = {{16{w_half[15]}}, w_half};
                3'b010:  ReadData = w_word;
                3'b100:  ReadData = {24'd0, w_byte};
                3'b101:  ReadData = {16'd0, w_half};
                default: ReadData = 32'd0;
            endcase
        end
    end

`ifdef DMEM_SIZED_CNT_EN
    // ------------------------------------------------------------------------
    // Saturating access counters
    // ------------------------------------------------------------------------
    logic [31:0] r_rdCnt;
    logic [31:0] r_wrCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdCnt <= 32'd0;
            r_wrCnt <= 32'd0;
        end else begin
            if (w_rdOk && (r_rdCnt != 32'hFFFF_FFFF)) begin
                r_rdCnt <= r_rdCnt + 32'd1;
            end
            if (w_wrOk && (r_wrCnt != 32'hFFFF_FFFF)) begin
                r_wrCnt <= r_wrCnt + 32'd1;
            end
        end
    end

    assign rd_cnt = r_rdCnt;
    assign wr_cnt = r_wrCnt;
`endif

endmodule
`default_nettype wire
